// File: rtl/slot_pkg.sv
// slot_pkg: shared Apple II slot-space address map, C8 ownership states and defaults.
package slot_pkg;

    localparam logic [7:0]  IO_BANKS [4] = '{8'h00, 8'h01, 8'hE0, 8'hE1};
    localparam logic [15:0] C0_DEV_LO    = 16'hC080;
    localparam logic [15:0] C0_DEV_HI    = 16'hC0FF;
    localparam logic [15:0] CN_LO        = 16'hC100;
    localparam logic [15:0] CN_HI        = 16'hC7FF;
    localparam logic [15:0] C8_LO        = 16'hC800;
    localparam logic [15:0] C8_HI        = 16'hCFFF;
    localparam logic [15:0] C8_RELEASE   = 16'hCFFF;
    localparam logic [7:0]  FLOAT_DEFAULT = 8'h80;

    typedef enum logic [1:0] {C8_NONE, C8_SLOT, C8_INTERNAL} c8_state_t;

    function automatic logic is_io_bank(input logic [7:0] b);
        is_io_bank = 1'b0;
        for (int i = 0; i < 4; i++)
            if (b == IO_BANKS[i]) is_io_bank = 1'b1;
    endfunction

endpackage

// File: rtl/slot_bus_decoder_c8_owner_fsm.sv
// c8_owner_fsm: tracks who owns the $C800-$CFFF expansion ROM window.
// Release wins over any claim presented in the same cycle.
module c8_owner_fsm
    import slot_pkg::*;
(
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       claim_slot,
    input  logic       claim_int,
    input  logic       release_c8,
    input  logic [2:0] slot,
    output c8_state_t  state,
    output logic [2:0] owner
);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state <= C8_NONE;
            owner <= 3'd0;
        end else if (release_c8) begin
            state <= C8_NONE;
            owner <= 3'd0;
        end else if (claim_slot) begin
            state <= C8_SLOT;
            owner <= slot;
        end else if (claim_int) begin
            state <= C8_INTERNAL;
            owner <= 3'd0;
        end
    end

endmodule

// File: rtl/slot_bus_decoder.sv
// slot_bus_decoder: registered per-slot DEVSEL/IOSEL/IOSTROBE decode, C8 ownership
// and card read-data mux for Apple II/IIgs peripheral slots.
module slot_bus_decoder
    import slot_pkg::*;
#(
    parameter int                 NUM_SLOTS = 7,
    parameter int                 DATA_W    = 8,
    parameter logic [DATA_W-1:0]  FLOAT_VAL = DATA_W'(FLOAT_DEFAULT)
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    input  logic                  phi0,
    input  logic [7:0]            bank,
    input  logic [15:0]           addr,
    input  logic                  we,
    input  logic [7:0]            sltromsel,
    input  logic                  intcxrom,
    input  logic [8*DATA_W-1:0]   slot_dout,
    input  logic [7:0]            slot_drive,
    output logic [7:0]            dev_sel,
    output logic [7:0]            io_sel,
    output logic [7:0]            io_strobe,
    output logic [2:0]            c8_owner,
    output logic                  c8_internal,
    output logic                  internal_rom_sel,
    output logic                  card_hit,
    output logic [DATA_W-1:0]     card_dout
);

    logic [7:0]        ext_en, dev_d, io_d, stb_d;
    logic              io, in_dev, in_cn, in_c8, irom_d, hit_d;
    logic [2:0]        dev_slot, cn_slot, sel_slot, owner;
    logic [DATA_W-1:0] dout_d;
    c8_state_t         state;
    logic              unused_we;

    // Reads and writes decode identically; the direction only matters to the cards.
    assign unused_we = we;

    always_comb begin
        ext_en = '0;
        for (int n = 1; n < 8; n++)
            ext_en[n] = sltromsel[n] && !intcxrom && n <= NUM_SLOTS;
    end

    assign io       = is_io_bank(bank);
    assign in_dev   = io && addr >= C0_DEV_LO && addr <= C0_DEV_HI;
    assign in_cn    = io && addr >= CN_LO && addr <= CN_HI;
    assign in_c8    = io && addr >= C8_LO && addr <= C8_HI;
    assign dev_slot = addr[6:4];
    assign cn_slot  = addr[10:8];

    assign dev_d  = (in_dev && dev_slot != 3'd0 && ext_en[dev_slot]) ? 8'b1 << dev_slot : 8'h00;
    assign io_d   = (in_cn && ext_en[cn_slot]) ? 8'b1 << cn_slot : 8'h00;
    // Ownership survives a revoke; only the strobe is gated by the live enable.
    assign stb_d  = (in_c8 && state == C8_SLOT && ext_en[owner]) ? 8'b1 << owner : 8'h00;
    assign irom_d = (in_cn && !ext_en[cn_slot]) || (in_c8 && stb_d == 8'h00);

    assign sel_slot = |dev_d ? dev_slot : |io_d ? cn_slot : owner;
    assign hit_d    = |(dev_d | io_d | stb_d) && slot_drive[sel_slot];
    assign dout_d   = hit_d ? slot_dout[sel_slot*DATA_W +: DATA_W] : FLOAT_VAL;

    c8_owner_fsm u_c8 (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .claim_slot (phi0 && in_cn && ext_en[cn_slot]),
        .claim_int  (phi0 && in_cn && !ext_en[cn_slot] && cn_slot == 3'd3),
        .release_c8 (phi0 && io && addr == C8_RELEASE),
        .slot       (cn_slot),
        .state      (state),
        .owner      (owner)
    );

    assign c8_owner    = owner;
    assign c8_internal = state == C8_INTERNAL;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dev_sel          <= '0;
            io_sel           <= '0;
            io_strobe        <= '0;
            internal_rom_sel <= 1'b0;
            card_hit         <= 1'b0;
            card_dout        <= FLOAT_VAL;
        end else begin
            dev_sel          <= dev_d;
            io_sel           <= io_d;
            io_strobe        <= stb_d;
            internal_rom_sel <= irom_d;
            card_hit         <= hit_d;
            card_dout        <= dout_d;
        end
    end

endmodule

// File: tb/tb_slot_bus_decoder.sv
// tb_slot_bus_decoder: scoreboard bench; a behavioural slot model predicts each
// registered response, a monitor pops and compares one cycle later.
module tb_slot_bus_decoder;

    logic        clk_sys = 0, reset_n = 0, phi0 = 0, we = 0, intcxrom = 0;
    logic [7:0]  bank = 0, sltromsel = 0, slot_drive = 0;
    logic [15:0] addr = 0;
    logic [63:0] slot_dout = 0;
    logic [7:0]  dev_sel, io_sel, io_strobe, card_dout;
    logic [2:0]  c8_owner;
    logic        c8_internal, internal_rom_sel, card_hit;

    typedef struct packed {
        logic [7:0] dev, io, stb;
        logic [2:0] own;
        logic       intl, irom, hit;
        logic [7:0] dout;
    } resp_t;

    resp_t       q[$];
    int          vectors = 0, miscompares = 0;
    int          m_owner = 0;
    bit          m_int = 0;
    logic [7:0]  nx_sr = 0, nx_drive = 0;
    logic        nx_ic = 0;
    logic [63:0] nx_dout = 0;

    slot_bus_decoder dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .phi0(phi0), .bank(bank), .addr(addr),
        .we(we), .sltromsel(sltromsel), .intcxrom(intcxrom), .slot_dout(slot_dout),
        .slot_drive(slot_drive), .dev_sel(dev_sel), .io_sel(io_sel), .io_strobe(io_strobe),
        .c8_owner(c8_owner), .c8_internal(c8_internal), .internal_rom_sel(internal_rom_sel),
        .card_hit(card_hit), .card_dout(card_dout)
    );

    always #5 clk_sys = ~clk_sys;

    function automatic resp_t dut_resp();
        return {dev_sel, io_sel, io_strobe, c8_owner, c8_internal, internal_rom_sel, card_hit, card_dout};
    endfunction

    function automatic bit ext(int n);
        return n >= 1 && n <= 7 && sltromsel[n] && !intcxrom;
    endfunction

    task automatic check(string name, resp_t act, resp_t exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got dev=%h io=%h stb=%h own=%0d int=%b irom=%b hit=%b dout=%h, expected dev=%h io=%h stb=%h own=%0d int=%b irom=%b hit=%b dout=%h",
                name, act.dev, act.io, act.stb, act.own, act.intl, act.irom, act.hit, act.dout,
                exp.dev, exp.io, exp.stb, exp.own, exp.intl, exp.irom, exp.hit, exp.dout);
        end
    endtask

    task automatic spot(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input logic [7:0] b, input logic [15:0] a, input logic p);
        resp_t e;
        bit    io;
        int    s, sel;
        @(negedge clk_sys);
        bank = b; addr = a; phi0 = p; we = 1'($urandom);
        sltromsel = nx_sr; intcxrom = nx_ic; slot_drive = nx_drive; slot_dout = nx_dout;
        io = b inside {8'h00, 8'h01, 8'hE0, 8'hE1};
        e = '0;
        sel = -1;
        if (io && a >= 16'hC080 && a <= 16'hC0FF) begin
            s = (a >> 4) & 7;
            if (s != 0 && ext(s)) begin e.dev = 8'(1 << s); sel = s; end
        end
        if (io && a >= 16'hC100 && a <= 16'hC7FF) begin
            s = (a >> 8) & 7;
            if (ext(s)) begin e.io = 8'(1 << s); sel = s; end
            else e.irom = 1;
        end
        if (io && a >= 16'hC800 && a <= 16'hCFFF) begin
            if (m_owner != 0 && ext(m_owner)) begin e.stb = 8'(1 << m_owner); sel = m_owner; end
            else e.irom = 1;
        end
        e.dout = 8'h80;
        if (sel >= 0 && nx_drive[sel]) begin e.hit = 1; e.dout = nx_dout[sel*8 +: 8]; end
        if (p && io) begin
            if (a == 16'hCFFF) begin m_owner = 0; m_int = 0; end
            else if (a >= 16'hC100 && a <= 16'hC7FF) begin
                s = (a >> 8) & 7;
                if (ext(s)) begin m_owner = s; m_int = 0; end
                else if (s == 3) begin m_owner = 0; m_int = 1; end
            end
        end
        e.own = 3'(m_owner);
        e.intl = m_int;
        q.push_back(e);
    endtask

    task automatic settle();
        @(posedge clk_sys);
        #2;
    endtask

    always @(posedge clk_sys) begin
        resp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("resp", dut_resp(), e);
        end
    end

    localparam resp_t RST = '{dev: 0, io: 0, stb: 0, own: 0, intl: 0, irom: 0, hit: 0, dout: 8'h80};

    initial begin
        logic [7:0] banks [6];
        logic [31:0] r;
        logic [15:0] a;
        int k;
        banks = '{8'h00, 8'h01, 8'hE0, 8'hE1, 8'h02, 8'h00};
        repeat (2) @(posedge clk_sys);
        #1 check("reset", dut_resp(), RST);
        @(negedge clk_sys) reset_n = 1;

        nx_sr = 8'h80; apply(8'h00, 16'hC0F3, 1);
        nx_sr = 8'h00; apply(8'h00, 16'hC0F3, 1);
        nx_sr = 8'h80; apply(8'h00, 16'hC700, 1);
        settle(); spot("claim7 owner", c8_owner, 7);
        apply(8'h00, 16'hC812, 1);
        settle(); spot("c8 strobe", io_strobe, 8'h80);
        apply(8'h00, 16'hCFFF, 1);
        settle(); spot("release strobe", io_strobe, 8'h80); spot("release owner", c8_owner, 0);
        apply(8'h00, 16'hC812, 1);
        settle(); spot("post release strobe", io_strobe, 0); spot("post release irom", internal_rom_sel, 1);
        apply(8'h00, 16'hC300, 1);
        settle(); spot("intc8 internal", c8_internal, 1);
        apply(8'h00, 16'hC700, 1);
        settle(); spot("reclaim owner", c8_owner, 7); spot("reclaim internal", c8_internal, 0);
        nx_drive = 8'h80; nx_dout[63:56] = 8'hA5; apply(8'h00, 16'hC0F0, 1);
        settle(); spot("card hit", card_hit, 1); spot("card dout", card_dout, 8'hA5);
        nx_drive = 8'h00; apply(8'h00, 16'hC0F0, 1);
        settle(); spot("card float", card_dout, 8'h80);
        nx_ic = 1; apply(8'h00, 16'hC900, 1);
        settle(); spot("revoked strobe", io_strobe, 0); spot("revoked irom", internal_rom_sel, 1);
        spot("revoked owner", c8_owner, 7);
        nx_ic = 0; apply(8'h00, 16'hC900, 1);
        settle(); spot("restored strobe", io_strobe, 8'h80);

        nx_sr = 8'h20; apply(8'h00, 16'hC500, 1);
        settle(); spot("claim5 owner", c8_owner, 5);
        apply(8'h00, 16'hC812, 1);
        #3 reset_n = 0;
        q.delete();
        m_owner = 0; m_int = 0;
        #1 check("async reset", dut_resp(), RST);
        bank = 8'h02; phi0 = 0;
        repeat (2) @(posedge clk_sys);
        @(negedge clk_sys) reset_n = 1;
        apply(8'h02, 16'hC500, 1);
        settle(); spot("bank02 io_sel", io_sel, 0); spot("bank02 owner", c8_owner, 0);

        repeat (600) begin
            r = $urandom;
            k = $urandom_range(0, 9);
            a = k < 3 ? {8'hC0, r[7:0]} : k < 6 ? {5'b11000, r[10:0]} :
                k < 8 ? {5'b11001, r[10:0]} : k == 8 ? 16'hCFFF : r[15:0];
            nx_sr    = 8'($urandom);
            nx_ic    = $urandom_range(0, 7) == 0;
            nx_drive = 8'($urandom);
            nx_dout  = {$urandom, $urandom};
            k = $urandom_range(0, 5);
            apply(k == 5 ? 8'($urandom) : banks[k], a, $urandom_range(0, 3) != 0);
        end

        repeat (4) @(posedge clk_sys);
        if (q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d responses never observed, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
